// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: format codes,
// RV32I base opcodes and the byte-writer FSM states.
package instr_encoder_loader_pkg;

  // Instruction format selector values; 6 and 7 are not defined.
  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_SB = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_UJ = 3'd5;

  // RV32I major opcodes, one representative per format.
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR0  = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_WR3  = 3'd4,
    ST_FULL = 3'd5
  } state_e;

  // Branch and jump offsets are halfword-aligned; bit 0 cannot be encoded.
  function automatic logic fmt_drops_imm0(input logic [2:0] f);
    return (f == FMT_SB) || (f == FMT_UJ);
  endfunction

endpackage

// File: rtl/rv_field_encoder.sv
// Combinational RV32I field packer: turns a format code, register/function
// fields and an immediate into one 32-bit machine word.
module rv_field_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic        [2:0]  i_fmt,
  input  logic        [6:0]  i_opcode,
  input  logic        [4:0]  i_rd,
  input  logic        [2:0]  i_func3,
  input  logic        [4:0]  i_rs1,
  input  logic        [4:0]  i_rs2,
  input  logic        [6:0]  i_func7,
  input  logic signed [31:0] i_imm,
  output logic        [31:0] o_word,
  output logic               o_fmt_invalid
);

  // Select the bit layout for the requested format; immediates are truncated.
  always_comb begin
    o_word        = '0;
    o_fmt_invalid = 1'b0;
    case (i_fmt)
      FMT_R:  o_word = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_opcode};
      FMT_I:  o_word = {i_imm[11:0], i_rs1, i_func3, i_rd, i_opcode};
      FMT_S:  o_word = {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_opcode};
      FMT_SB: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3,
                        i_imm[4:1], i_imm[11], i_opcode};
      FMT_U:  o_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_UJ: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                        i_rd, i_opcode};
      default: o_fmt_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts one instruction field set at a time, encodes it and
// streams the word little-endian into byte-addressed instruction memory,
// one byte per cycle, until memory is exhausted.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [2:0]         func3,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [6:0]         func7,
  input  logic signed [31:0] imm,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  output logic [31:0]        instr_out,
  output logic [ADDR_W-2:0]  word_cnt,
  output logic               done,
  output logic               full,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-2:0]   r_word_cnt;
  logic [31:0]         r_instr;
  logic                r_done;
  logic                r_full;
  logic                r_err;

  logic [31:0]         w_word;
  logic                w_fmt_invalid;
  logic                w_accept;
  logic                w_take_word;
  logic                w_odd_imm;
  logic [1:0]          w_byte_idx;
  logic [ADDR_W-1:0]   w_ptr_next;
  logic                w_wrap;

  rv_field_encoder u_enc (
    .i_fmt         (fmt),
    .i_opcode      (opcode),
    .i_rd          (rd),
    .i_func3       (func3),
    .i_rs1         (rs1),
    .i_rs2         (rs2),
    .i_func7       (func7),
    .i_imm         (imm),
    .o_word        (w_word),
    .o_fmt_invalid (w_fmt_invalid)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_take_word = w_accept && !w_fmt_invalid;
  assign w_odd_imm   = fmt_drops_imm0(fmt) && imm[0];
  assign w_ptr_next  = r_ptr + ADDR_W'(4);
  // The last word slot is reached when the advanced pointer wraps to zero.
  assign w_wrap      = (w_ptr_next == '0);

  // State register; async reset returns to IDLE so in_ready rises on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus handshake and byte-lane selection for the memory port.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    mem_we      = 1'b0;
    w_byte_idx  = 2'd0;
    case (r_state)
      ST_IDLE: begin
        // A clear in the same cycle would discard the word, so refuse it.
        in_ready = rst_n && !clr;
        if (w_take_word) begin
          w_state_nxt = ST_WR0;
        end
      end
      ST_WR0: begin
        mem_we      = 1'b1;
        w_byte_idx  = 2'd0;
        w_state_nxt = ST_WR1;
      end
      ST_WR1: begin
        mem_we      = 1'b1;
        w_byte_idx  = 2'd1;
        w_state_nxt = ST_WR2;
      end
      ST_WR2: begin
        mem_we      = 1'b1;
        w_byte_idx  = 2'd2;
        w_state_nxt = ST_WR3;
      end
      ST_WR3: begin
        mem_we      = 1'b1;
        w_byte_idx  = 2'd3;
        w_state_nxt = w_wrap ? ST_FULL : ST_IDLE;
      end
      ST_FULL: begin
        w_state_nxt = ST_FULL;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end
  end

  assign mem_addr  = r_ptr + ADDR_W'(w_byte_idx);
  assign mem_wdata = mem_we ? r_instr[{w_byte_idx, 3'b000} +: 8] : 8'h00;

  // Pointer, word counter and full flag advance once the fourth byte is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= LP_BASE;
      r_word_cnt <= '0;
      r_full     <= 1'b0;
    end else if (clr) begin
      r_ptr      <= LP_BASE;
      r_word_cnt <= '0;
      r_full     <= 1'b0;
    end else if (r_state == ST_WR3) begin
      r_ptr      <= w_ptr_next;
      r_word_cnt <= r_word_cnt + (ADDR_W-1)'(1);
      if (w_wrap) begin
        r_full <= 1'b1;
      end
    end
  end

  // Latch the encoded word on a valid accept; dropped formats leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
    end else if (w_take_word) begin
      r_instr <= w_word;
    end
  end

  // Sticky error: undefined format, or an odd branch/jump offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (clr) begin
      r_err <= 1'b0;
    end else if (w_accept && (w_fmt_invalid || w_odd_imm)) begin
      r_err <= 1'b1;
    end
  end

  // One-cycle completion pulse following the last byte of a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_WR3) && !clr;
    end
  end

  assign instr_out = r_instr;
  assign word_cnt  = r_word_cnt;
  assign done      = r_done;
  assign full      = r_full;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed program-load
// scenarios followed by randomized traffic, all compared every cycle against
// a transaction-level model built on a queue of pending byte writes.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int AW   = 4;
  localparam int MEMB = 1 << AW;
  localparam int BASE = 0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        func3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        func7;
  logic [31:0]       imm;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wdata;
  logic [31:0]       instr_out;
  logic [AW-2:0]     word_cnt;
  logic              done;
  logic              full;
  logic              err;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .func3     (func3),
    .rs1       (rs1),
    .rs2       (rs2),
    .func7     (func7),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .instr_out (instr_out),
    .word_cnt  (word_cnt),
    .done      (done),
    .full      (full),
    .err       (err)
  );

  // Instruction memory image as seen through the DUT write port.
  logic [7:0] tb_mem [MEMB];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding byte writes plus the architectural flags.
  typedef struct { int addr; logic [7:0] data; } wr_t;
  wr_t         m_q[$];
  int          m_ptr;
  int          m_cnt;
  logic        m_full;
  logic        m_err;
  logic        m_done;
  logic [31:0] m_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Field placement by shifting each field to its bit position.
  function automatic logic [32:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [2:0] f3, input logic [4:0] s1,
      input logic [4:0] s2, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] o;
    logic [31:0] base_rr;
    o = 32'(op);
    base_rr = (32'(s1) << 15) | (32'(f3) << 12);
    case (f)
      3'd0: w = (32'(f7) << 25) | (32'(s2) << 20) | base_rr | (32'(d) << 7) | o;
      3'd1: w = ((im & 32'hFFF) << 20) | base_rr | (32'(d) << 7) | o;
      3'd2: w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base_rr |
                ((im & 32'h1F) << 7) | o;
      3'd3: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) |
                (32'(s2) << 20) | base_rr | (((im >> 1) & 32'hF) << 8) |
                (((im >> 11) & 32'h1) << 7) | o;
      3'd4: w = (im & 32'hFFFFF000) | (32'(d) << 7) | o;
      3'd5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
                (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) |
                (32'(d) << 7) | o;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, w};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ptr   = BASE;
    m_cnt   = 0;
    m_full  = 1'b0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    m_instr = 32'h0;
  endtask

  function automatic logic exp_ready();
    return rst_n && (m_q.size() == 0) && !m_full && !clr;
  endfunction

  task automatic compare_all();
    logic busy;
    busy = (m_q.size() != 0);
    check("in_ready", 32'(in_ready), 32'(exp_ready()));
    check("mem_we", 32'(mem_we), 32'(busy));
    if (busy) begin
      check("mem_addr", 32'(mem_addr), 32'(m_q[0].addr));
      check("mem_wdata", 32'(mem_wdata), 32'(m_q[0].data));
    end
    check("done", 32'(done), 32'(m_done));
    check("full", 32'(full), 32'(m_full));
    check("err", 32'(err), 32'(m_err));
    check("word_cnt", 32'(word_cnt), 32'(m_cnt));
    check("instr_out", instr_out, m_instr);
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_update();
    logic        acc;
    logic [32:0] enc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = exp_ready() && in_valid;
    if (clr) begin
      m_q.delete();
      m_ptr  = BASE;
      m_cnt  = 0;
      m_full = 1'b0;
      m_err  = 1'b0;
      m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (m_q.size() != 0) begin
      m_q.delete(0);
      if (m_q.size() == 0) begin
        m_done = 1'b1;
        m_cnt++;
        m_ptr = (m_ptr + 4) % MEMB;
        if (m_ptr == 0) m_full = 1'b1;
      end
    end else if (acc) begin
      enc = ref_encode(fmt, opcode, rd, func3, rs1, rs2, func7, imm);
      if (enc[32]) begin
        m_err = 1'b1;
      end else begin
        m_instr = enc[31:0];
        if ((fmt == 3'd3 || fmt == 3'd5) && imm[0]) m_err = 1'b1;
        for (int k = 0; k < 4; k++) begin
          wr_t e;
          e.addr = (m_ptr + k) % MEMB;
          e.data = enc[8*k +: 8];
          m_q.push_back(e);
        end
      end
    end
  endtask

  // One clock cycle: check at the falling edge, then step the model.
  task automatic step();
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
      input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; func3 = f3; rs1 = s1; rs2 = s2; func7 = f7; imm = im;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
      input logic [6:0] f7, input logic [31:0] im);
    set_fields(f, op, d, f3, s1, s2, f7, im);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  logic [6:0] opc_tab [8];

  initial begin
    opc_tab[0] = OPC_OP;  opc_tab[1] = OPC_OP_IMM; opc_tab[2] = OPC_STORE;
    opc_tab[3] = OPC_BRANCH; opc_tab[4] = OPC_LUI; opc_tab[5] = OPC_JAL;
    opc_tab[6] = 7'h7F; opc_tab[7] = 7'h00;

    clr = 1'b0; in_valid = 1'b0;
    set_fields(3'd0, 7'h0, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0, 32'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    check("rst_instr_out", instr_out, 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'h1);

    // add x3,x1,x2
    send(3'd0, OPC_OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
    repeat (4) step();
    check("add_done_n5", 32'(done), 32'h1);
    check("add_instr", instr_out, 32'h002081B3);
    check("add_byte0", 32'(tb_mem[0]), 32'hB3);
    check("add_byte1", 32'(tb_mem[1]), 32'h81);
    check("add_byte2", 32'(tb_mem[2]), 32'h20);
    check("add_byte3", 32'(tb_mem[3]), 32'h00);
    check("add_cnt", 32'(word_cnt), 32'h1);
    do_clear();

    // addi x5,x0,-1 then sw x2,8(x1)
    send(3'd1, OPC_OP_IMM, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
    repeat (4) step();
    check("addi_instr", instr_out, 32'hFFF00293);
    send(3'd2, OPC_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    repeat (4) step();
    check("sw_instr", instr_out, 32'h0020A423);
    check("sw_cnt", 32'(word_cnt), 32'h2);

    // beq x0,x0,-4 and the odd-offset variant, which also fills memory
    send(3'd3, OPC_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC);
    repeat (4) step();
    check("beq_instr", instr_out, 32'hFE000EE3);
    check("beq_err", 32'(err), 32'h0);
    send(3'd3, OPC_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFD);
    check("beq_odd_err_n1", 32'(err), 32'h1);
    repeat (4) step();
    check("beq_odd_instr", instr_out, 32'hFE000EE3);
    check("beq_odd_byte3", 32'(tb_mem[15]), 32'hFE);
    check("full_set", 32'(full), 32'h1);
    check("full_ready", 32'(in_ready), 32'h0);
    check("full_cnt", 32'(word_cnt), 32'h4);

    // A fifth request is held off while full
    set_fields(3'd0, OPC_OP, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'h0);
    in_valid = 1'b1;
    repeat (6) step();
    check("held_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    do_clear();
    check("clr_full", 32'(full), 32'h0);
    check("clr_ptr", 32'(mem_addr), 32'h0);
    check("clr_cnt", 32'(word_cnt), 32'h0);

    // Undefined format is swallowed with an error and no writes
    send(3'd7, OPC_OP, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'h0);
    repeat (5) step();
    check("bad_fmt_err", 32'(err), 32'h1);
    check("bad_fmt_ready", 32'(in_ready), 32'h1);
    check("bad_fmt_instr", instr_out, 32'hFE000EE3);
    do_clear();

    // Clear during the second byte aborts the word
    send(3'd0, OPC_OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_wr1_we", 32'(mem_we), 32'h0);
    check("clr_wr1_cnt", 32'(word_cnt), 32'h0);
    repeat (5) step();

    // Reset during the third byte
    send(3'd0, OPC_OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
    repeat (2) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_wr2_we", 32'(mem_we), 32'h0);
    check("rst_wr2_instr", instr_out, 32'h0);
    check("rst_wr2_cnt", 32'(word_cnt), 32'h0);
    check("rst_wr2_ready", 32'(in_ready), 32'h0);
    check("rst_wr2_addr", 32'(mem_addr), 32'(BASE));
    check("rst_wr2_wdata", 32'(mem_wdata), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int it = 0; it < 3000; it++) begin
      logic [2:0] f;
      logic [31:0] im;
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      im = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 8191)) - 4096);
      set_fields(f, ($urandom_range(0, 7) == 0) ? 7'($urandom) : opc_tab[f],
                 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom), im);
      in_valid = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 59) == 0) || (m_full && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
      step();
    end
    clr = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encodes RV32I instruction fields into 32-bit machine words and writes each word, one byte per cycle, into the byte-addressed instruction memory. It performs the inverse of the decode-side field split: opcode, rd, func3, rs1, rs2, func7 and an immediate go in, and a little-endian byte stream to instruction memory comes out. It sits between the testbench/boot program source and instruction memory. It loads a program before the core is released from reset.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of instruction memory (2^ADDR_W bytes; must be ≥ 3)
- BASE_ADDR, 0, first byte address written after reset/clear (must be 4-aligned)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- clr  in  1  synchronous clear of pointer, flags and state
- in_valid  in  1  field set presented
- in_ready  out  1  block can accept a field set
- fmt  in  3  0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ; 6–7 invalid
- opcode  in  7 / rd  in  5 / func3  in  3 / rs1  in  5 / rs2  in  5 / func7  in  7  instruction fields
- imm  in  32  immediate as a signed byte-offset value
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte data
- instr_out  out  32  last accepted encoded word
- word_cnt  out  ADDR_W-1  words written since reset/clear
- done  out  1  one-cycle pulse after the 4th byte of a word is written
- full  out  1  memory exhausted (sticky)
- err  out  1  sticky: invalid fmt or odd SB/UJ immediate

## Operation
- Encoding rules ({} denotes concatenation, MSB first):
  - R: {func7, rs2, rs1, func3, rd, opcode}
  - I: {imm[11:0], rs1, func3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}
  - SB: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Unused fields are ignored. No range checking of imm; excess bits are truncated.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch the encoded word into instr_out and go to WR0.
  - WR0..WR3: mem_we=1, mem_addr=ptr+k, mem_wdata=word[8k+7:8k] (little-endian). After WR3, ptr+=4 and word_cnt+=1. If the written word was the last one (ptr+4 wraps to 0 relative to memory size), set full and go to FULL; otherwise go to IDLE.
  - FULL: in_ready=0, no writes. Only clr or rst_n exits this state.
- Invalid fmt (6, 7) is accepted (handshake completes) and dropped: err is set, there is no write, the state stays IDLE, and instr_out is unchanged.
- SB/UJ with imm[0]=1: err is set, but the word is encoded (imm[0] dropped) and written.
- clr has priority over everything except rst_n:
  - ptr=BASE_ADDR, word_cnt=0, full=0, err=0, state=IDLE.
  - A word in progress is aborted, and mem_we is low from the next cycle.
- Reset values: in_ready=0 while rst_n is low, then 1 in IDLE. mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, instr_out=0, word_cnt=0, done=0, full=0, err=0.
- rst_n asserted mid-write terminates the write immediately (asynchronous). The partial word stays in memory.

## Timing
- Handshake completes in cycle N when in_valid&&in_ready. The bytes are written in cycles N+1..N+4.
- In cycle N+5: done=1 and in_ready=1, so the next accept can occur in N+5. Peak throughput is one word per 5 cycles.
- in_ready is low in WR0–WR3 and FULL. Inputs need only be stable in the accept cycle.
- instr_out updates in N+1. word_cnt and full update in N+5.
- err updates in the cycle after the accept (N+1).

## Structure
- Shared package: the fmt encodings (FMT_R..FMT_UJ), the RV32I opcode constants, and the FSM state enum.
- One sub-module, `rv_field_encoder`: purely combinational, fmt + fields + imm → 32-bit word + fmt_invalid. The top level holds the FSM, pointer, counters and memory port.

## Test plan
- R, add x3,x1,x2 (op 0x33, rd3, f3 0, rs1 1, rs2 2, f7 0) → instr_out 0x002081B3. Bytes B3,81,20,00 at addr 0–3. done at N+5.
- I, addi x5,x0,-1 (op 0x13, imm 0xFFFFFFFF), then S, sw x2,8(x1) (op 0x23, f3 2, imm 8) → 0xFFF00293 then 0x0020A423. word_cnt=2.
- SB, beq x0,x0,-4 (op 0x63, imm -4) → 0xFE000EE3, err=0. Same with imm=-3 → err=1 and the word is still written.
- fmt=7 with in_valid → err=1, no mem_we for 5 cycles, in_ready stays 1.
- ADDR_W=4: four back-to-back words → full=1 after the 4th, in_ready=0. A 5th in_valid is held with no writes. clr → ptr 0, full=0.
- clr asserted in WR1 → mem_we=0 from the next cycle, word_cnt=0. Same test with rst_n low in WR2 → all outputs at reset values immediately.
